// File: rtl/mdu_mc_if.sv
// Operand, command and result bundle between the multicycle controller and the HI/LO multiply/divide unit.
// start is honoured only while busy is low; done pulses for one cycle when hi/lo take a new result.
interface mdu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_mc.sv
// Multicycle HI/LO multiply/divide unit: one bit per clock (shift-add multiply, restoring divide),
// signs handled by magnitude arithmetic plus a final fix-up cycle.
module mdu_mc #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_mc_if.slave    mdu,
    output logic [1:0] o_dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_raw_a;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic               r_is_div;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_last;

    assign w_abs_a = (mdu.op[0] && mdu.src_a[WIDTH-1]) ? -mdu.src_a : mdu.src_a;
    assign w_abs_b = (mdu.op[0] && mdu.src_b[WIDTH-1]) ? -mdu.src_b : mdu.src_b;

    // Multiply: multiplier sits in the low half of the accumulator and shifts out as the product shifts in.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);

    // Divide: the shifted partial remainder needs WIDTH+1 bits; once it is >= divisor, the true
    // difference is below the divisor, so the low WIDTH bits of the subtraction are exact.
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opd});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opd;

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_quo : r_quo;
    assign w_rem  = r_neg_rem ? -r_rem : r_rem;
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opd     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_raw_a   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_is_div  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mdu.hi_we) r_hi <= mdu.wr_data;
                    if (mdu.lo_we) r_lo <= mdu.wr_data;
                    if (mdu.start) begin
                        r_opd     <= mdu.op[1] ? w_abs_b : w_abs_a;
                        r_acc     <= {{WIDTH{1'b0}}, w_abs_b};
                        r_rem     <= '0;
                        r_quo     <= w_abs_a;
                        r_raw_a   <= mdu.src_a;
                        r_neg_res <= mdu.op[0] & (mdu.src_a[WIDTH-1] ^ mdu.src_b[WIDTH-1]);
                        r_neg_rem <= mdu.op[0] & mdu.src_a[WIDTH-1];
                        r_dz      <= (mdu.src_b == '0);
                        r_is_div  <= mdu.op[1];
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= mdu.op[1] ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= S_FIX;
                end
                S_DIV: begin
                    r_rem <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_div_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= S_FIX;
                end
                S_FIX: begin
                    // Divide by zero reports the raw dividend and an all-ones quotient, signed or not.
                    if (r_is_div && r_dz) begin
                        r_hi <= r_raw_a;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mdu.busy    = r_busy;
    assign mdu.done    = r_done;
    assign mdu.hi      = r_hi;
    assign mdu.lo      = r_lo;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mdu_mc.sv
// Bench for mdu_mc: directed cases, HI/LO write rules, reset abort, back-to-back starts and random ops,
// all checked against an arithmetic reference model.
module tb_mdu_mc;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_res;

    mdu_mc_if #(.WIDTH(W)) bus ();

    mdu_mc #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .mdu         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} from plain arithmetic on 64-bit values.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        model = '0;
        case (op)
            2'b00: model = {32'h0, a} * {32'h0, b};
            2'b01: model = sa * sb;
            default: begin
                if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
                else if (op == 2'b10) model = {a % b, a / b};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
        endcase
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        exp_q.push_back(model(op, a, b));
        tick();
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.src_a = $urandom;
        bus.src_b = $urandom;
    endtask

    task automatic wait_done(input string tag, input int elapsed);
        int n;
        int bc;
        logic [63:0] exp;
        n  = elapsed;
        bc = 0;
        while (!bus.done && n < 100) begin
            if (bus.busy) bc++;
            tick();
            n++;
        end
        exp = exp_q.pop_front();
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'd33);
        if (elapsed == 0) check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
        check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
        last_res = exp;
    endtask

    logic [1:0]  d_op[7] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10};
    logic [31:0] d_a[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                             32'd100, 32'h8000_0000, 32'h0000_1234};
    logic [31:0] d_b[7]  = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                             32'd7, 32'hFFFF_FFFF, 32'h0};

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wr_data = '0;
        last_res    = '0;
        repeat (3) tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        tick();

        // Directed cases; each start after the first lands on the previous done cycle.
        for (int i = 0; i < 7; i++) begin
            start_op(d_op[i], d_a[i], d_b[i]);
            wait_done($sformatf("dir%0d", i), 0);
        end
        check("dir_divu_zero_hi", 64'(bus.hi), 64'h1234);
        check("dir_divu_zero_lo", 64'(bus.lo), 64'hFFFF_FFFF);

        tick();
        bus.hi_we = 1'b1; bus.wr_data = 32'hA5A5_A5A5;
        tick();
        bus.hi_we = 1'b0;
        check("mthi", 64'(bus.hi), 64'hA5A5_A5A5);
        bus.lo_we = 1'b1; bus.wr_data = 32'h5A5A_0F0F;
        tick();
        bus.lo_we = 1'b0;
        check("mtlo", 64'(bus.lo), 64'h5A5A_0F0F);
        check("mtlo_hi_kept", 64'(bus.hi), 64'hA5A5_A5A5);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h1357_9BDF;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("mt_both_hi", 64'(bus.hi), 64'h1357_9BDF);
        check("mt_both_lo", 64'(bus.lo), 64'h1357_9BDF);
        last_res = {32'h1357_9BDF, 32'h1357_9BDF};

        // mthi together with start: the write lands now, the result overwrites it at the end.
        bus.hi_we = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
        start_op(2'b00, 32'd3, 32'd5);
        bus.hi_we = 1'b0;
        check("mt_with_start", 64'(bus.hi), 64'hDEAD_BEEF);
        wait_done("mt_start_op", 0);

        // Writes and a second start during busy are ignored.
        tick();
        start_op(2'b11, 32'hFFFF_FF85, 32'd9);
        repeat (5) tick();
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'hFFFF_0000;
        repeat (3) tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("busy_hi_hold", 64'(bus.hi), 64'(last_res[63:32]));
        check("busy_lo_hold", 64'(bus.lo), 64'(last_res[31:0]));
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd1; bus.src_b = 32'd1;
        tick();
        bus.start = 1'b0;
        wait_done("busy_ignore", 9);

        // Reset after iteration 10 aborts; a fresh op then completes.
        tick();
        start_op(2'b00, $urandom, $urandom);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_front());
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        start_op(2'b10, 32'hFFFF_FFFF, 32'd10);
        wait_done("after_abort", 0);
        start_op(2'b01, 32'h7FFF_FFFF, 32'h8000_0001);
        wait_done("back_to_back", 0);

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       r_b = 32'h0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = $urandom_range(1, 15);
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) tick();
            start_op(r_op, r_a, r_b);
            wait_done($sformatf("rnd%0d_op%0d", i, r_op), 0);
        end

        tick();
        check("final_done_low", 64'(bus.done), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_mc.md
# mdu_mc

Parametrised multicycle multiply/divide unit that adds HI/LO arithmetic (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) to the multicycle MIPS datapath. It sits beside the ALU and takes operands from the A and B operand registers. It iterates one bit per clock and holds its result in internal HI/LO registers. The control FSM starts an operation, stalls on `busy`, and reads `hi`/`lo` through the MemtoReg path.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: start request; sampled only in IDLE.
- `op`, input, 2: 00 multu, 01 mult, 10 divu, 11 div; sampled with `start`.
- `src_a`, input, WIDTH: multiplicand or dividend.
- `src_b`, input, WIDTH: multiplier or divisor.
- `hi_we`, input, 1: mthi; loads `wr_data` into HI.
- `lo_we`, input, 1: mtlo; loads `wr_data` into LO.
- `wr_data`, input, WIDTH: mthi/mtlo data.
- `busy`, output, 1: high while an operation is in flight.
- `done`, output, 1: one-cycle pulse when HI/LO take a new result.
- `hi`, output, WIDTH: HI register (product high half or remainder).
- `lo`, output, WIDTH: LO register (product low half or quotient).

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with `start`=1:
  - Latch operand magnitudes; for signed ops use the two's-complement absolute value.
  - Latch the result-sign flags and the raw `src_a`.
  - Clear the iteration counter (width clog2(WIDTH)+1).
  - Go to MUL (op[1]=0) or DIV (op[1]=1). Assert `busy`.
- MUL: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator. After WIDTH iterations go to FIX.
- DIV: restoring divide, one quotient bit per cycle, with a WIDTH+1-bit partial remainder. After WIDTH iterations go to FIX.
- FIX:
  - Apply signs. Product is negated (2·WIDTH-bit negate) if operand signs differ. Quotient is negated if signs differ. Remainder takes the sign of the dividend.
  - Write {hi,lo}, pulse `done`, deassert `busy`, return to IDLE.
- Divide by zero: no trap; completes with normal latency. Result is hi = raw `src_a`, lo = all ones, for both div and divu.
- Signed overflow (most-negative / −1) needs no special case: the natural result is lo = most-negative, hi = 0.
- `start` while busy: ignored; no queuing.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE; ignored while busy, because the controller stalls.
  - Simultaneous with `start`: the write takes effect, then is overwritten by the result at FIX.
  - `hi_we` and `lo_we` together: both registers load `wr_data`.
- `op` and `src_*` are don't-care after the start cycle.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0. Reset mid-operation aborts and restores these on the next edge.
- Start accepted at edge E0. `busy`=1 from E0 up to edge E(WIDTH+1).
- Iterations occur on edges E1..E(WIDTH); FIX occurs at E(WIDTH+1).
- At E(WIDTH+1): `hi`/`lo` update, `done`=1 for exactly one cycle, `busy`=0.
- Latency: start to result is WIDTH+1 clocks, which is 33 at WIDTH=32.
- A new `start` is accepted in the same cycle `done` is high, giving back-to-back operations with no bubble.
- mthi/mtlo: `hi`/`lo` are visible the cycle after the write edge.
- `hi`/`lo` are registered; they hold their value during busy and change only at FIX, on an mt write, or on reset.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → `done` 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; `busy` high for exactly 33 cycles.
- mult −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then mult 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- div −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100 / 7 → lo=14, hi=2. div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu 0x1234 / 0 → hi=0x1234, lo=0xFFFFFFFF, with normal 33-cycle latency.
- mthi 0xA5A5A5A5 in IDLE → hi updates the next cycle. mtlo asserted while busy → lo unchanged. `start` pulsed mid-operation → ignored, and the original result is correct.
- Assert `rst` at iteration 10 → next cycle `busy`=0, `done`=0, hi=lo=0. A new start then completes correctly. Back-to-back start on the `done` cycle → second result after 33 more cycles.
